net_rx: RTL and testbench
=========================

Name: net_rx

Overview:
- RGMII receive path for the 1000BASE-T link. Counterpart of the fixed-frame transmitter.
- Captures DDR nibbles on clk125, strips preamble/SFD, computes Ethernet CRC32 and removes the 4-byte FCS.
- Delivers the frame as a byte stream with start/end markers and a good/bad status on the last byte.
- Sits between the PHY RX pins and the packet consumer logic.

Parameters:
- MAX_LEN, 1522, maximum accepted bytes after SFD, FCS included; longer frames are flagged bad.
- MIN_LEN, 64, minimum bytes after SFD, FCS included; shorter frames are flagged bad but still streamed if at least 1 payload byte exists.
- MAX_PRE, 7, maximum 0x55 preamble bytes accepted before SFD.

Ports:
- clk125  input  1  125 MHz RX clock; both edges used for capture.
- rst  input  1  asynchronous, active-high reset.
- rxctl  input  1  RGMII RX_CTL: RX_DV on the rising edge, RX_DV^RX_ER on the falling edge.
- rxd  input  4  RGMII data: low nibble on the rising edge, high nibble on the falling edge.
- out_data  output  8  payload byte; FCS never appears here.
- out_valid  output  1  out_data valid, one cycle per byte.
- out_sof  output  1  first byte after SFD; qualified by out_valid.
- out_eof  output  1  last payload byte; qualified by out_valid.
- out_ok  output  1  frame good; meaningful only with out_eof.

Behaviour:
- Reset (async, active-high) forces out_valid/out_sof/out_eof/out_ok=0, out_data=0, state IDLE, delay line cleared, CRC=0xFFFFFFFF.

DDR capture:
- Rising edge: low nibble and dv.
- Falling edge: high nibble and dv^er.
- Assembled byte {hi,lo} and flags dv, er are presented at the next rising edge.
- er = dv & ~(falling-edge ctl).

State machine:
- IDLE: dv=0 stays. dv=1 with byte 0x55 → PRE (pre_cnt=1). dv=1 with any other byte → DROP.
- PRE: 0x55 with pre_cnt<MAX_PRE → pre_cnt+1. 0xD5 → DATA (CRC=0xFFFFFFFF, len=0). Any other byte, or pre_cnt overflow → DROP. dv=0 → IDLE.
- DATA: each dv byte updates CRC (reflected, poly 0xEDB88320, LSB first), increments len (saturating 11 bits) and enters the 5-byte delay line. dv=0 → END.
- END: one cycle; emits tail and status, then → IDLE.
- DROP: wait for dv=0 → IDLE; no output.
- Rising dv while in DATA/DROP is impossible by construction; dv must be low for ≥1 cycle between frames.

Delay line and output:
- 5-entry shift register. When it holds 5 bytes and a new byte arrives, the oldest is emitted (out_valid=1).
- out_sof on the first emitted byte of a frame.
- In END, the oldest held entry is the last payload byte. It is emitted with out_eof=1; the 4 remaining entries (FCS) are discarded.
- Latency: the byte captured at posedge n is emitted at posedge n+5 while the stream is continuous.
- out_ok = (CRC register == 0xDEBB20E3) & ~er_seen & (MIN_LEN ≤ len ≤ MAX_LEN).
- Frames with len ≤ 4 produce no output at all.
- er_seen is set by any er during DATA.
- A frame with len=5 emits a single byte with out_sof=out_eof=1.

Reset and timing:
- Reset mid-frame aborts with no eof.
- If dv=1 at reset release, the block enters DROP instead of IDLE, so it never syncs mid-frame.
- No backpressure: the consumer must accept one byte per cycle.

Optional Feature:
- Macro NET_RX_STATS_EN.
- Defined: adds outputs stat_good[15:0] and stat_bad[15:0], both reset to 0. Each increments (saturating at 0xFFFF) on every out_eof according to out_ok. stat_bad also increments on every DROP entry from PRE.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package net_pkg holds:
  - rx state enum: IDLE, PRE, DATA, END, DROP.
  - Constants: CRC_POLY 0xEDB88320, CRC_INIT 0xFFFFFFFF, CRC_RESIDUE 0xDEBB20E3, PREAMBLE 0x55, SFD 0xD5.
  - The shared byte-wise crc32 function, so TX and RX use one definition.
- One sub-module: net_rgmii_ddr_in, which does the dual-edge capture and produces byte, dv and er on the rising edge.

Test Plan:
- Good frame: 7×0x55, 0xD5, 14 header bytes, 200×0x39, correct FCS. Expect 214 out_valid bytes, out_sof on the first header byte, out_eof on the last 0x39, out_ok=1.
- Same frame with one payload bit flipped → identical stream, out_eof with out_ok=0.
- Preamble 0x55,0x55,0x54 then data → no output; after dv drops, the following good frame is received normally.
- RX_ER pulsed for one cycle mid-payload of a good frame → out_ok=0 at eof. With NET_RX_STATS_EN: stat_bad=1, stat_good unchanged.
- Length bounds: 1600-byte payload with valid FCS → out_ok=0. 40-byte frame with valid FCS → 36 bytes streamed, out_ok=0. Frame of SFD+3 bytes → no output.
- rst asserted mid-payload while dv remains high → outputs 0 immediately, no eof. Remainder of the frame is dropped; next frame out_ok=1.

Source files
------------

// File: rtl/net_pkg.sv
// Shared Ethernet RX/TX definitions: receive FSM states, framing constants, byte-wise CRC32.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package net_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        END,
        DROP
    } rx_state_e;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;

    // Reflected CRC32 over one byte, LSB first, no final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/net_rgmii_ddr_in.sv
// RGMII DDR capture: rising edge low nibble + RX_DV, falling edge high nibble + RX_DV^RX_ER.
// Latency: byte/dv/er presented on the rising edge after the rising edge that took the low nibble.
// Backpressure: none; ports: clk125, rst, rxctl, rxd[3:0] in; rx_byte[7:0], rx_dv, rx_er out.
module net_rgmii_ddr_in (
    input  logic       clk125,
    input  logic       rst,
    input  logic       rxctl,
    input  logic [3:0] rxd,
    output logic [7:0] rx_byte,
    output logic       rx_dv,
    output logic       rx_er
);

    logic [3:0] lo_q;
    logic       dv_q;
    logic [3:0] hi_q;
    logic       ctlf_q;
    logic [7:0] byte_q, byte_d;
    logic       dv_out_q, dv_out_d;
    logic       er_q, er_d;

    // dv flops reset high so that, after reset release, the receiver sees a
    // "frame in progress" and must observe dv low before it can sync to a
    // preamble. This keeps it from locking onto the middle of a frame.
    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            lo_q <= 4'h0;
            dv_q <= 1'b1;
        end else begin
            lo_q <= rxd;
            dv_q <= rxctl;
        end
    end

    always_ff @(negedge clk125 or posedge rst) begin
        if (rst) begin
            hi_q   <= 4'h0;
            ctlf_q <= 1'b1;
        end else begin
            hi_q   <= rxd;
            ctlf_q <= rxctl;
        end
    end

    always_comb begin
        byte_d   = {hi_q, lo_q};
        dv_out_d = dv_q;
        er_d     = dv_q & ~ctlf_q;
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            byte_q   <= 8'h00;
            dv_out_q <= 1'b1;
            er_q     <= 1'b0;
        end else begin
            byte_q   <= byte_d;
            dv_out_q <= dv_out_d;
            er_q     <= er_d;
        end
    end

    assign rx_byte = byte_q;
    assign rx_dv   = dv_out_q;
    assign rx_er   = er_q;

endmodule

// File: rtl/net_rx.sv
// RGMII receive path: strips preamble/SFD, checks CRC32/length/RX_ER, removes FCS, streams payload.
// Latency: payload byte leaves 5 cycles after it enters the FCS delay line; status rides the last byte.
// Backpressure: none, consumer takes one byte per cycle. Ports: clk125, rst, rxctl, rxd[3:0] in;
// out_data[7:0], out_valid, out_sof, out_eof, out_ok out; NET_RX_STATS_EN adds stat_good/stat_bad[15:0].
module net_rx
    import net_pkg::*;
#(
    parameter int MAX_LEN = 1522,
    parameter int MIN_LEN = 64,
    parameter int MAX_PRE = 7
) (
    input  logic        clk125,
    input  logic        rst,
    input  logic        rxctl,
    input  logic [3:0]  rxd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_ok
`ifdef NET_RX_STATS_EN
    ,
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad
`endif
);

    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);
    localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
    localparam logic [3:0]  MAX_PRE_W = 4'(MAX_PRE);

    logic [7:0] in_byte;
    logic       in_dv;
    logic       in_er;

    net_rgmii_ddr_in u_ddr (
        .clk125  (clk125),
        .rst     (rst),
        .rxctl   (rxctl),
        .rxd     (rxd),
        .rx_byte (in_byte),
        .rx_dv   (in_dv),
        .rx_er   (in_er)
    );

    rx_state_e       state_q, state_d;
    logic [3:0]      pre_cnt_q, pre_cnt_d;
    logic [31:0]     crc_q, crc_d;
    logic [10:0]     len_q, len_d;
    logic            er_seen_q, er_seen_d;
    logic            first_q, first_d;
    logic [4:0][7:0] dly_q, dly_d;       // [0] newest, [4] oldest
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sof_q, out_sof_d;
    logic            out_eof_q, out_eof_d;
    logic            out_ok_q, out_ok_d;

    logic dly_full;
    logic frame_ok;

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        crc_d       = crc_q;
        len_d       = len_q;
        er_seen_d   = er_seen_q;
        first_d     = first_q;
        dly_d       = dly_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        out_ok_d    = 1'b0;

        // len never decreases within a frame, so len >= 5 means the delay line is full.
        dly_full = (len_q >= 11'd5);
        frame_ok = (crc_q == CRC_RESIDUE) && !er_seen_q &&
                   (len_q >= MIN_LEN_W) && (len_q <= MAX_LEN_W);

        case (state_q)
            IDLE, END: begin
                if (state_q == END) begin
                    // Oldest held entry is the last payload byte; the other four are FCS.
                    if (dly_full) begin
                        out_valid_d = 1'b1;
                        out_data_d  = dly_q[4];
                        out_sof_d   = first_q;
                        out_eof_d   = 1'b1;
                        out_ok_d    = frame_ok;
                    end
                    first_d = 1'b0;
                    state_d = IDLE;
                end
                // END is also the first idle cycle, so a preamble that starts
                // right after a one-cycle dv gap is not lost.
                if (in_dv) begin
                    if (in_byte == PREAMBLE) begin
                        state_d   = PRE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PRE: begin
                if (!in_dv) begin
                    state_d = IDLE;
                end else if (in_byte == PREAMBLE) begin
                    if (pre_cnt_q < MAX_PRE_W) begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end else begin
                        state_d = DROP;
                    end
                end else if (in_byte == SFD) begin
                    state_d   = DATA;
                    crc_d     = CRC_INIT;
                    len_d     = 11'd0;
                    er_seen_d = 1'b0;
                    first_d   = 1'b1;
                end else begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (in_dv) begin
                    crc_d     = crc32_byte(crc_q, in_byte);
                    len_d     = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
                    er_seen_d = er_seen_q | in_er;
                    dly_d     = {dly_q[3:0], in_byte};
                    if (dly_full) begin
                        out_valid_d = 1'b1;
                        out_data_d  = dly_q[4];
                        out_sof_d   = first_q;
                        first_d     = 1'b0;
                    end
                end else begin
                    state_d = END;
                end
            end
            DROP: begin
                if (!in_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pre_cnt_q   <= 4'd0;
            crc_q       <= CRC_INIT;
            len_q       <= 11'd0;
            er_seen_q   <= 1'b0;
            first_q     <= 1'b0;
            dly_q       <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            er_seen_q   <= er_seen_d;
            first_q     <= first_d;
            dly_q       <= dly_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_ok_q    <= out_ok_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_ok    = out_ok_q;

`ifdef NET_RX_STATS_EN
    logic [15:0] stat_good_q, stat_good_d;
    logic [15:0] stat_bad_q, stat_bad_d;
    logic        drop_from_pre;

    assign drop_from_pre = (state_q == PRE) && (state_d == DROP);

    // Counters step on the same edge that presents the eof byte.
    always_comb begin
        stat_good_d = stat_good_q;
        stat_bad_d  = stat_bad_q;
        if (out_eof_d && out_ok_d && (stat_good_q != 16'hFFFF)) begin
            stat_good_d = stat_good_q + 16'd1;
        end
        if (((out_eof_d && !out_ok_d) || drop_from_pre) && (stat_bad_q != 16'hFFFF)) begin
            stat_bad_d = stat_bad_q + 16'd1;
        end
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            stat_good_q <= 16'd0;
            stat_bad_q  <= 16'd0;
        end else begin
            stat_good_q <= stat_good_d;
            stat_bad_q  <= stat_bad_d;
        end
    end

    assign stat_good = stat_good_q;
    assign stat_bad  = stat_bad_q;
`endif

endmodule

// File: tb/tb_net_rx.sv
module tb_net_rx;

    typedef logic [7:0] bq_t[$];

    logic       clk125 = 1'b0;
    logic       rst;
    logic       rxctl;
    logic [3:0] rxd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sof;
    logic       out_eof;
    logic       out_ok;
`ifdef NET_RX_STATS_EN
    logic [15:0] stat_good;
    logic [15:0] stat_bad;
`endif

    always #4 clk125 = ~clk125;

    net_rx dut (
        .clk125    (clk125),
        .rst       (rst),
        .rxctl     (rxctl),
        .rxd       (rxd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_ok    (out_ok)
`ifdef NET_RX_STATS_EN
        ,
        .stat_good (stat_good),
        .stat_bad  (stat_bad)
`endif
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [31:0] crc_tab [256];

    function automatic void build_table();
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end
    endfunction

    // Standard Ethernet FCS value (complemented table-driven CRC32).
    function automatic logic [31:0] fcs_of(input bq_t d);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[i]) c = crc_tab[c[7:0] ^ d[i]] ^ (c >> 8);
        return ~c;
    endfunction

    function automatic bq_t with_fcs(input bq_t p);
        bq_t f;
        logic [31:0] fcs;
        f   = p;
        fcs = fcs_of(p);
        f.push_back(fcs[7:0]);
        f.push_back(fcs[15:8]);
        f.push_back(fcs[23:16]);
        f.push_back(fcs[31:24]);
        return f;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Payload as the consumer should see it: everything but the trailing 4 FCS bytes.
    function automatic bq_t strip_fcs(input bq_t f);
        bq_t q;
        for (int i = 0; i < f.size() - 4; i++) q.push_back(f[i]);
        return q;
    endfunction

    function automatic logic model_ok(input bq_t f, input logic er);
        bq_t body;
        logic [31:0] stored;
        int n;
        n = f.size();
        if (n < 5) return 1'b0;
        body   = strip_fcs(f);
        stored = {f[n-1], f[n-2], f[n-3], f[n-4]};
        return (fcs_of(body) == stored) && !er && (n >= 64) && (n <= 1522);
    endfunction

    // ---------------- output monitor ----------------
    logic [7:0] got_data[$];
    bit         got_sof[$];
    int         sof_cnt = 0;
    int         eof_cnt = 0;
    int         eof_idx = -1;
    logic       last_ok = 1'b0;

    always @(negedge clk125) begin
        if (!rst && out_valid) begin
            got_data.push_back(out_data);
            got_sof.push_back(out_sof);
            if (out_sof) sof_cnt++;
            if (out_eof) begin
                eof_cnt++;
                eof_idx = got_data.size() - 1;
                last_ok = out_ok;
            end
        end
    end

    task automatic clear_mon();
        got_data.delete();
        got_sof.delete();
        sof_cnt = 0;
        eof_cnt = 0;
        eof_idx = -1;
        last_ok = 1'b0;
    endtask

    function automatic int first_diff(input bq_t e);
        for (int i = 0; i < e.size() && i < got_data.size(); i++)
            if (got_data[i] !== e[i]) return i;
        return -1;
    endfunction

    // ---------------- PHY driver ----------------
    // Called just after a falling edge; returns just after the next falling edge.
    task automatic drive_cycle(input logic dv, input logic er, input logic [7:0] b);
        #2;
        rxd   = b[3:0];
        rxctl = dv;
        @(posedge clk125);
        #2;
        rxd   = b[7:4];
        rxctl = dv ^ er;
        @(negedge clk125);
    endtask

    task automatic send_frame(input bq_t f, input int npre, input int er_at, input int gap);
        for (int i = 0; i < npre; i++) drive_cycle(1'b1, 1'b0, 8'h55);
        drive_cycle(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < f.size(); i++) drive_cycle(1'b1, (i == er_at), f[i]);
        for (int i = 0; i < gap; i++) drive_cycle(1'b0, 1'b0, 8'h00);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b1;
        rxctl = 1'b0;
        rxd   = 4'h0;
        repeat (3) @(negedge clk125);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_sof !== 1'b0)   begin errors++; $display("FAIL reset_sof got %b exp 0", out_sof); end
        checks++; if (out_eof !== 1'b0)   begin errors++; $display("FAIL reset_eof got %b exp 0", out_eof); end
        checks++; if (out_ok !== 1'b0)    begin errors++; $display("FAIL reset_ok got %b exp 0", out_ok); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
        rst = 1'b0;
        repeat (6) @(negedge clk125);
        checks++; if (got_data.size() != 0) begin errors++; $display("FAIL idle_quiet got %0d bytes exp 0", got_data.size()); end
    endtask

    task automatic test_good_frame();
        bq_t p, f, e;
        p = rand_bytes(14);
        repeat (200) p.push_back(8'h39);
        f = with_fcs(p);
        e = strip_fcs(f);
        clear_mon();
        send_frame(f, 7, -1, 12);
        checks++; if (got_data.size() != e.size()) begin errors++; $display("FAIL good_count got %0d exp %0d", got_data.size(), e.size()); end
        checks++; if (first_diff(e) != -1) begin errors++; $display("FAIL good_data first bad index %0d exp -1", first_diff(e)); end
        checks++; if (sof_cnt != 1 || got_sof[0] !== 1'b1) begin errors++; $display("FAIL good_sof got count %0d first %b exp 1 1", sof_cnt, got_sof[0]); end
        checks++; if (eof_cnt != 1 || eof_idx != e.size() - 1) begin errors++; $display("FAIL good_eof got count %0d idx %0d exp 1 %0d", eof_cnt, eof_idx, e.size() - 1); end
        checks++; if (last_ok !== model_ok(f, 1'b0)) begin errors++; $display("FAIL good_ok got %b exp %b", last_ok, model_ok(f, 1'b0)); end
    endtask

    task automatic test_bad_crc();
        bq_t p, f, e;
        p = rand_bytes(14);
        repeat (200) p.push_back(8'h39);
        f = with_fcs(p);
        f[100] = f[100] ^ 8'h10;
        e = strip_fcs(f);
        clear_mon();
        send_frame(f, 7, -1, 12);
        checks++; if (got_data.size() != e.size()) begin errors++; $display("FAIL crc_count got %0d exp %0d", got_data.size(), e.size()); end
        checks++; if (first_diff(e) != -1) begin errors++; $display("FAIL crc_data first bad index %0d exp -1", first_diff(e)); end
        checks++; if (eof_cnt != 1 || last_ok !== model_ok(f, 1'b0)) begin errors++; $display("FAIL crc_ok got eofs %0d ok %b exp 1 %b", eof_cnt, last_ok, model_ok(f, 1'b0)); end
    endtask

    task automatic test_bad_preamble();
        bq_t junk, f, e;
        junk = rand_bytes(30);
        clear_mon();
        drive_cycle(1'b1, 1'b0, 8'h55);
        drive_cycle(1'b1, 1'b0, 8'h55);
        drive_cycle(1'b1, 1'b0, 8'h54);
        foreach (junk[i]) drive_cycle(1'b1, 1'b0, junk[i]);
        repeat (12) drive_cycle(1'b0, 1'b0, 8'h00);
        checks++; if (got_data.size() != 0 || eof_cnt != 0) begin errors++; $display("FAIL pre_drop got %0d bytes %0d eofs exp 0 0", got_data.size(), eof_cnt); end
        f = with_fcs(rand_bytes(80));
        e = strip_fcs(f);
        clear_mon();
        send_frame(f, 7, -1, 12);
        checks++; if (got_data.size() != e.size() || first_diff(e) != -1) begin errors++; $display("FAIL pre_next_data got %0d bytes diff %0d exp %0d -1", got_data.size(), first_diff(e), e.size()); end
        checks++; if (eof_cnt != 1 || last_ok !== model_ok(f, 1'b0)) begin errors++; $display("FAIL pre_next_ok got eofs %0d ok %b exp 1 %b", eof_cnt, last_ok, model_ok(f, 1'b0)); end
    endtask

    task automatic test_rx_er();
        bq_t f, e;
`ifdef NET_RX_STATS_EN
        logic [15:0] g0, b0;
        g0 = stat_good;
        b0 = stat_bad;
`endif
        f = with_fcs(rand_bytes(114));
        e = strip_fcs(f);
        clear_mon();
        send_frame(f, 7, 50, 12);
        checks++; if (got_data.size() != e.size() || first_diff(e) != -1) begin errors++; $display("FAIL er_data got %0d bytes diff %0d exp %0d -1", got_data.size(), first_diff(e), e.size()); end
        checks++; if (eof_cnt != 1 || last_ok !== model_ok(f, 1'b1)) begin errors++; $display("FAIL er_ok got eofs %0d ok %b exp 1 %b", eof_cnt, last_ok, model_ok(f, 1'b1)); end
`ifdef NET_RX_STATS_EN
        checks++; if (stat_bad !== b0 + 16'd1) begin errors++; $display("FAIL er_stat_bad got %0d exp %0d", stat_bad, b0 + 16'd1); end
        checks++; if (stat_good !== g0) begin errors++; $display("FAIL er_stat_good got %0d exp %0d", stat_good, g0); end
`endif
    endtask

    task automatic test_length();
        int lens[8] = '{1604, 40, 3, 5, 64, 63, 1522, 1523};
        foreach (lens[k]) begin
            bq_t f, e;
            int n;
            logic exp_ok;
            n = lens[k];
            f = (n > 4) ? with_fcs(rand_bytes(n - 4)) : rand_bytes(n);
            e = (n > 4) ? strip_fcs(f) : rand_bytes(0);
            exp_ok = model_ok(f, 1'b0);
            clear_mon();
            send_frame(f, 7, -1, 12);
            checks++; if (got_data.size() != e.size()) begin errors++; $display("FAIL len%0d_count got %0d exp %0d", n, got_data.size(), e.size()); end
            checks++; if (first_diff(e) != -1) begin errors++; $display("FAIL len%0d_data first bad index %0d exp -1", n, first_diff(e)); end
            checks++; if (eof_cnt != ((n > 4) ? 1 : 0)) begin errors++; $display("FAIL len%0d_eofs got %0d exp %0d", n, eof_cnt, (n > 4) ? 1 : 0); end
            if (n > 4) begin
                checks++; if (eof_idx != e.size() - 1 || sof_cnt != 1 || got_sof[0] !== 1'b1) begin errors++; $display("FAIL len%0d_marks got eof_idx %0d sofs %0d exp %0d 1", n, eof_idx, sof_cnt, e.size() - 1); end
                checks++; if (last_ok !== exp_ok) begin errors++; $display("FAIL len%0d_ok got %b exp %b", n, last_ok, exp_ok); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bq_t f1, f2, e;
        f1 = with_fcs(rand_bytes(70));
        f2 = with_fcs(rand_bytes(90));
        e  = strip_fcs(f1);
        foreach (f2[i]) if (i < f2.size() - 4) e.push_back(f2[i]);
        clear_mon();
        send_frame(f1, 7, -1, 1);
        send_frame(f2, 7, -1, 12);
        checks++; if (got_data.size() != e.size() || first_diff(e) != -1) begin errors++; $display("FAIL b2b_data got %0d bytes diff %0d exp %0d -1", got_data.size(), first_diff(e), e.size()); end
        checks++; if (eof_cnt != 2 || sof_cnt != 2 || last_ok !== model_ok(f2, 1'b0)) begin errors++; $display("FAIL b2b_marks got eofs %0d sofs %0d ok %b exp 2 2 %b", eof_cnt, sof_cnt, last_ok, model_ok(f2, 1'b0)); end
    endtask

    task automatic test_reset_mid();
        bq_t f, g, e;
        int n0;
        f = with_fcs(rand_bytes(200));
        clear_mon();
        repeat (7) drive_cycle(1'b1, 1'b0, 8'h55);
        drive_cycle(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 100; i++) drive_cycle(1'b1, 1'b0, f[i]);
        #1 rst = 1'b1;
        #1;
        n0 = got_data.size();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rstmid_outputs got valid %b data %h exp 0 00", out_valid, out_data); end
        checks++; if (n0 == 0) begin errors++; $display("FAIL rstmid_prefix got %0d bytes before reset exp >0", n0); end
        @(negedge clk125);
        for (int i = 100; i < 103; i++) drive_cycle(1'b1, 1'b0, f[i]);
        rst = 1'b0;
        for (int i = 103; i < f.size(); i++) drive_cycle(1'b1, 1'b0, f[i]);
        repeat (12) drive_cycle(1'b0, 1'b0, 8'h00);
        checks++; if (got_data.size() != n0 || eof_cnt != 0) begin errors++; $display("FAIL rstmid_tail got %0d bytes %0d eofs exp %0d 0", got_data.size(), eof_cnt, n0); end
        g = with_fcs(rand_bytes(100));
        e = strip_fcs(g);
        clear_mon();
        send_frame(g, 7, -1, 12);
        checks++; if (got_data.size() != e.size() || first_diff(e) != -1) begin errors++; $display("FAIL rstmid_next_data got %0d bytes diff %0d exp %0d -1", got_data.size(), first_diff(e), e.size()); end
        checks++; if (eof_cnt != 1 || last_ok !== model_ok(g, 1'b0)) begin errors++; $display("FAIL rstmid_next_ok got eofs %0d ok %b exp 1 %b", eof_cnt, last_ok, model_ok(g, 1'b0)); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        rxctl = 1'b0;
        rxd   = 4'h0;
        build_table();
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_bad_preamble();
        test_rx_er();
        test_length();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
